// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path and a saturating-increment helper
// used by the drop counter of the AXI4-Stream bridge.
package uart_pkg;

    // Default byte width; has to match the UART receiver.
    localparam int UART_DATA_BITS = 8;

    // Default byte that marks the end of a packet when TLAST generation is built in.
    localparam logic [7:0] UART_TERM_CHAR = 8'h0D;

    // Width of the dropped-byte counter.
    localparam int DROP_CNT_W = 8;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] value);
        logic [DROP_CNT_W-1:0] result;
        if (value == {DROP_CNT_W{1'b1}}) begin
            result = value;
        end else begin
            result = value + DROP_CNT_W'(1);
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers and a registered occupancy count.
// push/pop are qualified by the parent: pop is never issued when empty, and push
// when full is only issued together with a pop, which frees the slot being written.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [PW-1:0]    wr_ptr_nxt_s;
    logic [PW-1:0]    rd_ptr_nxt_s;
    logic [PW-1:0]    level_r;

    // Next pointer values; the wrap bit rolls over with the address bits.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        if (push) begin
            wr_ptr_nxt_s = wr_ptr_r + PW'(1);
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (pop) begin
            rd_ptr_nxt_s = rd_ptr_r + PW'(1);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
    end

    // Pointer and occupancy registers; level tracks wr_ptr - rd_ptr after every edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            level_r  <= {PW{1'b0}};
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            level_r  <= wr_ptr_nxt_s - rd_ptr_nxt_s;
        end
    end

    // Storage write; contents need no reset because empty masks them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        end
    end

    assign pop_data = mem_r[rd_ptr_r[AW-1:0]];
    assign empty    = (wr_ptr_r == rd_ptr_r);
    assign full     = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
    assign level    = level_r;

endmodule

// File: rtl/uart_rx_axis_bridge.sv
// UART receiver to AXI4-Stream bridge. Buffers the un-throttleable rx byte strobe
// in a DEPTH-entry FIFO, drops and counts bytes that arrive while it is full.
// Optional feature macro: UART_AXIS_TLAST_EN -- when defined, each entry carries a
// tlast bit set when the byte equals TERM_CHAR; otherwise m_axis_tlast is 0.
module uart_rx_axis_bridge
    import uart_pkg::*;
#(
    parameter int                   DATA_BITS = UART_DATA_BITS,
    parameter int                   DEPTH     = 16,
    parameter logic [DATA_BITS-1:0] TERM_CHAR = DATA_BITS'(UART_TERM_CHAR)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_BITS-1:0]     rx_data,
    input  logic                     rx_valid,
    output logic [DATA_BITS-1:0]     m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    input  logic                     ovf_clr,
    output logic                     ovf_flag,
    output logic [DROP_CNT_W-1:0]    drop_cnt,
    output logic [$clog2(DEPTH):0]   fill_level
);

`ifdef UART_AXIS_TLAST_EN
    localparam int ENTRY_W = DATA_BITS + 1;
`else
    localparam int ENTRY_W = DATA_BITS;
`endif

    logic                  fifo_empty_s;
    logic                  fifo_full_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  ovf_s;
    logic [ENTRY_W-1:0]    wr_entry_s;
    logic [ENTRY_W-1:0]    rd_entry_s;
    logic                  ovf_flag_r;
    logic [DROP_CNT_W-1:0] drop_cnt_r;

    // A pop happens whenever the consumer takes the head byte. A push is accepted
    // when there is room, or when a same-cycle pop makes room in a full FIFO.
    assign pop_s  = !fifo_empty_s && m_axis_tready;
    assign push_s = rx_valid && (!fifo_full_s || pop_s);
    assign ovf_s  = rx_valid && fifo_full_s && !pop_s;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data (wr_entry_s),
        .pop       (pop_s),
        .pop_data  (rd_entry_s),
        .empty     (fifo_empty_s),
        .full      (fifo_full_s),
        .level     (fill_level)
    );

`ifdef UART_AXIS_TLAST_EN
    // Packet-end marker is evaluated once, at push, and travels with its byte.
    always_comb begin
        wr_entry_s = {(rx_data == TERM_CHAR), rx_data};
    end

    // Head entry drives the stream; masked to zero while nothing is buffered.
    always_comb begin
        m_axis_tdata = {DATA_BITS{1'b0}};
        m_axis_tlast = 1'b0;
        if (!fifo_empty_s) begin
            m_axis_tdata = rd_entry_s[DATA_BITS-1:0];
            m_axis_tlast = rd_entry_s[DATA_BITS];
        end else begin
            m_axis_tdata = {DATA_BITS{1'b0}};
            m_axis_tlast = 1'b0;
        end
    end
`else
    logic unused_term_s;

    // Entries hold the bare byte; the terminator compare is kept only as a sink.
    always_comb begin
        wr_entry_s    = rx_data;
        unused_term_s = (rx_data == TERM_CHAR);
    end

    // Head entry drives the stream; masked to zero while nothing is buffered.
    always_comb begin
        m_axis_tdata = {DATA_BITS{1'b0}};
        m_axis_tlast = 1'b0;
        if (!fifo_empty_s) begin
            m_axis_tdata = rd_entry_s;
        end else begin
            m_axis_tdata = {DATA_BITS{1'b0}};
        end
    end
`endif

    assign m_axis_tvalid = !fifo_empty_s;

    // Overflow bookkeeping; a drop in the same cycle as a clear wins and leaves count 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_flag_r <= 1'b0;
            drop_cnt_r <= {DROP_CNT_W{1'b0}};
        end else if (ovf_s) begin
            ovf_flag_r <= 1'b1;
            if (ovf_clr) begin
                drop_cnt_r <= DROP_CNT_W'(1);
            end else begin
                drop_cnt_r <= sat_inc(drop_cnt_r);
            end
        end else if (ovf_clr) begin
            ovf_flag_r <= 1'b0;
            drop_cnt_r <= {DROP_CNT_W{1'b0}};
        end else begin
            ovf_flag_r <= ovf_flag_r;
            drop_cnt_r <= drop_cnt_r;
        end
    end

    assign ovf_flag = ovf_flag_r;
    assign drop_cnt = drop_cnt_r;

endmodule

// File: tb/tb_uart_rx_axis_bridge.sv
// Self-checking bench for uart_rx_axis_bridge. A queue-based reference model
// tracks buffered bytes, drops and the sticky flag; scenario tasks compare the
// DUT against it and against hand-derived constants.
module tb_uart_rx_axis_bridge;

    localparam int DATA_BITS = 8;
    localparam int DEPTH     = 16;
    localparam int LW        = $clog2(DEPTH) + 1;

    logic                 clk;
    logic                 rst_n;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic [DATA_BITS-1:0] m_axis_tdata;
    logic                 m_axis_tvalid;
    logic                 m_axis_tready;
    logic                 m_axis_tlast;
    logic                 ovf_clr;
    logic                 ovf_flag;
    logic [7:0]           drop_cnt;
    logic [LW-1:0]        fill_level;

    int pass_cnt;
    int chk_cnt;

    // Reference model state
    logic [7:0] model_q[$];
    int         model_drop;
    logic       model_flag;

    uart_rx_axis_bridge #(
        .DATA_BITS (DATA_BITS),
        .DEPTH     (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .ovf_clr       (ovf_clr),
        .ovf_flag      (ovf_flag),
        .drop_cnt      (drop_cnt),
        .fill_level    (fill_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic exp_tlast(input logic [7:0] b);
`ifdef UART_AXIS_TLAST_EN
        return (b == 8'h0D);
`else
        return 1'b0;
`endif
    endfunction

    // Apply the behaviour of one clock edge to the model, then advance past the edge.
    task automatic cycle();
        bit do_pop;
        bit do_push;
        bit do_drop;
        do_pop  = (model_q.size() > 0) && m_axis_tready;
        do_push = rx_valid && ((model_q.size() < DEPTH) || do_pop);
        do_drop = rx_valid && !do_push;
        if (do_pop)  void'(model_q.pop_front());
        if (do_push) model_q.push_back(rx_data);
        if (do_drop) begin
            model_flag = 1'b1;
            model_drop = ovf_clr ? 1 : ((model_drop < 255) ? model_drop + 1 : 255);
        end else if (ovf_clr) begin
            model_flag = 1'b0;
            model_drop = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n         = 1'b0;
        rx_valid      = 1'b0;
        rx_data       = 8'h00;
        m_axis_tready = 1'b0;
        ovf_clr       = 1'b0;
        model_q.delete();
        model_drop = 0;
        model_flag = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        chk_cnt++; if (m_axis_tvalid !== 1'b0) $display("FAIL reset_tvalid: got %0b want 0", m_axis_tvalid); else pass_cnt++;
        chk_cnt++; if (m_axis_tdata !== 8'h00) $display("FAIL reset_tdata: got %h want 00", m_axis_tdata); else pass_cnt++;
        chk_cnt++; if (m_axis_tlast !== 1'b0) $display("FAIL reset_tlast: got %0b want 0", m_axis_tlast); else pass_cnt++;
        chk_cnt++; if (fill_level !== 5'd0) $display("FAIL reset_fill: got %0d want 0", fill_level); else pass_cnt++;
        chk_cnt++; if (ovf_flag !== 1'b0 || drop_cnt !== 8'd0) $display("FAIL reset_ovf: got flag %0b cnt %0d want 0 0", ovf_flag, drop_cnt); else pass_cnt++;
    endtask

    task automatic test_single();
        apply_reset();
        rx_valid = 1'b1; rx_data = 8'hA5;
        cycle();
        rx_valid = 1'b0;
        chk_cnt++; if (m_axis_tvalid !== 1'b1) $display("FAIL single_tvalid: got %0b want 1", m_axis_tvalid); else pass_cnt++;
        chk_cnt++; if (m_axis_tdata !== 8'hA5) $display("FAIL single_tdata: got %h want a5", m_axis_tdata); else pass_cnt++;
        chk_cnt++; if (fill_level !== 5'd1) $display("FAIL single_fill: got %0d want 1", fill_level); else pass_cnt++;
        m_axis_tready = 1'b1;
        cycle();
        chk_cnt++; if (m_axis_tvalid !== 1'b0 || fill_level !== 5'd0) $display("FAIL single_pop: got tvalid %0b fill %0d want 0 0", m_axis_tvalid, fill_level); else pass_cnt++;
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            rx_valid = 1'b1; rx_data = 8'(i);
            cycle();
        end
        rx_valid = 1'b0;
        chk_cnt++; if (fill_level !== 5'd16) $display("FAIL ovf_fill16: got %0d want 16", fill_level); else pass_cnt++;
        chk_cnt++; if (ovf_flag !== 1'b0) $display("FAIL ovf_flag_before: got %0b want 0", ovf_flag); else pass_cnt++;
        rx_valid = 1'b1; rx_data = 8'h10;
        cycle();
        rx_valid = 1'b0;
        chk_cnt++; if (drop_cnt !== 8'd1 || ovf_flag !== 1'b1) $display("FAIL ovf_drop: got cnt %0d flag %0b want 1 1", drop_cnt, ovf_flag); else pass_cnt++;
        chk_cnt++; if (fill_level !== 5'd16) $display("FAIL ovf_fill_after: got %0d want 16", fill_level); else pass_cnt++;
        m_axis_tready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk_cnt++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'(i)) $display("FAIL ovf_drain[%0d]: got v%0b %h want v1 %h", i, m_axis_tvalid, m_axis_tdata, 8'(i)); else pass_cnt++;
            cycle();
        end
        chk_cnt++; if (m_axis_tvalid !== 1'b0 || fill_level !== 5'd0) $display("FAIL ovf_drained: got tvalid %0b fill %0d want 0 0", m_axis_tvalid, fill_level); else pass_cnt++;
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp_b;
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            rx_valid = 1'b1; rx_data = 8'h20 + 8'(i);
            cycle();
        end
        rx_data = 8'hEE; m_axis_tready = 1'b1;
        cycle();
        rx_valid = 1'b0;
        chk_cnt++; if (fill_level !== 5'd16) $display("FAIL fpp_fill: got %0d want 16", fill_level); else pass_cnt++;
        chk_cnt++; if (drop_cnt !== 8'd0 || ovf_flag !== 1'b0) $display("FAIL fpp_nodrop: got cnt %0d flag %0b want 0 0", drop_cnt, ovf_flag); else pass_cnt++;
        for (int i = 0; i < 16; i++) begin
            exp_b = (i < 15) ? 8'h21 + 8'(i) : 8'hEE;
            chk_cnt++; if (m_axis_tdata !== exp_b || exp_b !== model_q[0]) $display("FAIL fpp_drain[%0d]: got %h want %h", i, m_axis_tdata, exp_b); else pass_cnt++;
            cycle();
        end
        chk_cnt++; if (m_axis_tvalid !== 1'b0) $display("FAIL fpp_empty: got tvalid %0b want 0", m_axis_tvalid); else pass_cnt++;
    endtask

    task automatic test_random_stream();
        int   pushes;
        int   cyc;
        bit   hold;
        logic [7:0] hold_data;
        apply_reset();
        pushes = 0;
        cyc    = 0;
        while ((pushes < 1000 || model_q.size() > 0) && cyc < 8000) begin
            m_axis_tready = 1'($urandom_range(0, 1));
            rx_valid = (pushes < 1000) && (model_q.size() < DEPTH) && ($urandom_range(0, 2) != 0);
            rx_data  = 8'($urandom);
            if (rx_valid) pushes++;
            hold      = m_axis_tvalid && !m_axis_tready;
            hold_data = m_axis_tdata;
            cycle();
            cyc++;
            rx_valid = 1'b0;
            if (hold) begin
                chk_cnt++; if (m_axis_tdata !== hold_data) $display("FAIL rnd_stable cyc %0d: got %h want %h", cyc, m_axis_tdata, hold_data); else pass_cnt++;
            end
            chk_cnt++; if (m_axis_tvalid !== (model_q.size() > 0)) $display("FAIL rnd_tvalid cyc %0d: got %0b want %0b", cyc, m_axis_tvalid, (model_q.size() > 0)); else pass_cnt++;
            chk_cnt++; if (fill_level !== LW'(model_q.size())) $display("FAIL rnd_fill cyc %0d: got %0d want %0d", cyc, fill_level, model_q.size()); else pass_cnt++;
            if (model_q.size() > 0) begin
                chk_cnt++; if (m_axis_tdata !== model_q[0] || m_axis_tlast !== exp_tlast(model_q[0])) $display("FAIL rnd_head cyc %0d: got %h/%0b want %h/%0b", cyc, m_axis_tdata, m_axis_tlast, model_q[0], exp_tlast(model_q[0])); else pass_cnt++;
            end
        end
        chk_cnt++; if (pushes != 1000 || model_q.size() != 0) $display("FAIL rnd_budget: got pushes %0d left %0d want 1000 0", pushes, model_q.size()); else pass_cnt++;
        chk_cnt++; if (drop_cnt !== 8'd0 || ovf_flag !== 1'b0) $display("FAIL rnd_nodrop: got cnt %0d flag %0b want 0 0", drop_cnt, ovf_flag); else pass_cnt++;
    endtask

    task automatic test_saturate_clear();
        apply_reset();
        for (int i = 0; i < 300; i++) begin
            rx_valid = 1'b1; rx_data = 8'(i);
            cycle();
        end
        rx_valid = 1'b0;
        chk_cnt++; if (drop_cnt !== 8'd255 || drop_cnt !== 8'(model_drop)) $display("FAIL sat_cnt: got %0d want 255", drop_cnt); else pass_cnt++;
        chk_cnt++; if (ovf_flag !== 1'b1 || fill_level !== 5'd16) $display("FAIL sat_state: got flag %0b fill %0d want 1 16", ovf_flag, fill_level); else pass_cnt++;
        chk_cnt++; if (m_axis_tdata !== 8'h00) $display("FAIL sat_head: got %h want 00", m_axis_tdata); else pass_cnt++;
        ovf_clr = 1'b1; rx_valid = 1'b1; rx_data = 8'h77;
        cycle();
        rx_valid = 1'b0;
        chk_cnt++; if (ovf_flag !== 1'b1 || drop_cnt !== 8'd1) $display("FAIL clr_with_ovf: got flag %0b cnt %0d want 1 1", ovf_flag, drop_cnt); else pass_cnt++;
        cycle();
        ovf_clr = 1'b0;
        chk_cnt++; if (ovf_flag !== 1'b0 || drop_cnt !== 8'd0) $display("FAIL clr_only: got flag %0b cnt %0d want 0 0", ovf_flag, drop_cnt); else pass_cnt++;
    endtask

    task automatic test_tlast();
        logic [7:0] msg [3];
        logic       exp_last;
        msg[0] = 8'h41; msg[1] = 8'h42; msg[2] = 8'h0D;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            rx_valid = 1'b1; rx_data = msg[i];
            cycle();
        end
        rx_valid = 1'b0;
        m_axis_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
`ifdef UART_AXIS_TLAST_EN
            exp_last = (i == 2);
`else
            exp_last = 1'b0;
`endif
            chk_cnt++; if (m_axis_tdata !== msg[i] || m_axis_tlast !== exp_last) $display("FAIL tlast[%0d]: got %h/%0b want %h/%0b", i, m_axis_tdata, m_axis_tlast, msg[i], exp_last); else pass_cnt++;
            cycle();
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            rx_valid = 1'b1; rx_data = 8'hC0 + 8'(i);
            cycle();
        end
        rx_valid = 1'b0;
        chk_cnt++; if (fill_level !== 5'd5) $display("FAIL midrst_pre: got fill %0d want 5", fill_level); else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        chk_cnt++; if (m_axis_tvalid !== 1'b0 || fill_level !== 5'd0) $display("FAIL midrst_async: got tvalid %0b fill %0d want 0 0", m_axis_tvalid, fill_level); else pass_cnt++;
        model_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        chk_cnt++; if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 8'h00) $display("FAIL midrst_after: got tvalid %0b tdata %h want 0 00", m_axis_tvalid, m_axis_tdata); else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0;
        chk_cnt  = 0;
        test_reset();
        test_single();
        test_overflow();
        test_full_push_pop();
        test_random_stream();
        test_saturate_clear();
        test_tlast();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
